// File: rtl/lcdi_index_gen_pkg.sv
// Shared constants, class encoding and the index helper for the LCDI gradient-class index generator.
package lcdi_index_gen_pkg;

   localparam int unsigned LCDI_IDX_W     = 7;
   localparam int unsigned LCDI_NUM_CLASS = 9;

   typedef enum logic [3:0] {
      CLS_POS_MAX = 4'd0,
      CLS_POS_HI  = 4'd1,
      CLS_POS_MID = 4'd2,
      CLS_POS_LO  = 4'd3,
      CLS_ZERO    = 4'd4,
      CLS_NEG_LO  = 4'd5,
      CLS_NEG_MID = 4'd6,
      CLS_NEG_HI  = 4'd7,
      CLS_NEG_MAX = 4'd8
   } lcdi_class_e;

   function automatic logic [LCDI_IDX_W-1:0] lcdi_index(input logic [3:0] c0, input logic [3:0] c1);
      return LCDI_IDX_W'(c0) + LCDI_IDX_W'(c1) * LCDI_IDX_W'(LCDI_NUM_CLASS);
   endfunction

endpackage

// File: rtl/lcdi_grad_classify.sv
// Quantises a signed neighbour difference into one of nine symmetric gradient classes.
module lcdi_grad_classify
   import lcdi_index_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned T1         = 4,
   parameter int unsigned T2         = 16,
   parameter int unsigned T3         = 32,
   parameter int unsigned T4         = 48
) (
   input  logic signed [DATA_WIDTH:0] diff_i,
   output logic [3:0]                 cls_o
);

   localparam logic signed [DATA_WIDTH:0] P1 = (DATA_WIDTH+1)'(T1);
   localparam logic signed [DATA_WIDTH:0] P2 = (DATA_WIDTH+1)'(T2);
   localparam logic signed [DATA_WIDTH:0] P3 = (DATA_WIDTH+1)'(T3);
   localparam logic signed [DATA_WIDTH:0] P4 = (DATA_WIDTH+1)'(T4);
   localparam logic signed [DATA_WIDTH:0] N1 = -P1;
   localparam logic signed [DATA_WIDTH:0] N2 = -P2;
   localparam logic signed [DATA_WIDTH:0] N3 = -P3;
   localparam logic signed [DATA_WIDTH:0] N4 = -P4;

   always_comb begin
      if      (diff_i >= P4) cls_o = CLS_POS_MAX;
      else if (diff_i >= P3) cls_o = CLS_POS_HI;
      else if (diff_i >= P2) cls_o = CLS_POS_MID;
      else if (diff_i >= P1) cls_o = CLS_POS_LO;
      else if (diff_i >= N1) cls_o = CLS_ZERO;
      else if (diff_i >= N2) cls_o = CLS_NEG_LO;
      else if (diff_i >= N3) cls_o = CLS_NEG_MID;
      else if (diff_i >= N4) cls_o = CLS_NEG_HI;
      else                   cls_o = CLS_NEG_MAX;
   end

endmodule

// File: rtl/lcdi_index_gen.sv
// Two-stage gradient-class index generator: classify and register, then write the index into its slot and emit the bundle.
module lcdi_index_gen
   import lcdi_index_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   parameter int unsigned T1         = 4,
   parameter int unsigned T2         = 16,
   parameter int unsigned T3         = 32,
   parameter int unsigned T4         = 48
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           data0_in,
   input  logic [DATA_WIDTH-1:0]           data1_in,
   input  logic [DATA_WIDTH-1:0]           data2_in,
   input  logic [SLOT_W-1:0]               in_slot,
   input  logic                            in_last,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LCDI_IDX_W*NUM_SLOTS-1:0] index_flat,
   output logic [NUM_SLOTS-1:0]            slot_mask
);

   logic signed [DATA_WIDTH:0] diff0, diff1;
   logic [3:0]                 cls0, cls1;
   logic                       stall, accept, wr, fire;
   logic [LCDI_IDX_W-1:0]      idx;

   logic                            v1_q, v1_d, last_q, last_d, out_valid_q, out_valid_d;
   logic [3:0]                      c0_q, c0_d, c1_q, c1_d;
   logic [SLOT_W-1:0]               slot_q, slot_d;
   logic [NUM_SLOTS-1:0]            mask_q, mask_d;
   logic [LCDI_IDX_W*NUM_SLOTS-1:0] index_q, index_d;

   assign diff0 = $signed({1'b0, data0_in}) - $signed({1'b0, data1_in});
   assign diff1 = $signed({1'b0, data2_in}) - $signed({1'b0, data1_in});

   lcdi_grad_classify #(.DATA_WIDTH(DATA_WIDTH), .T1(T1), .T2(T2), .T3(T3), .T4(T4)) u_cls0 (
      .diff_i (diff0),
      .cls_o  (cls0)
   );

   lcdi_grad_classify #(.DATA_WIDTH(DATA_WIDTH), .T1(T1), .T2(T2), .T3(T3), .T4(T4)) u_cls1 (
      .diff_i (diff1),
      .cls_o  (cls1)
   );

   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;
   assign wr       = v1_q && !stall;
   assign fire     = out_valid_q && out_ready;
   assign idx      = lcdi_index(c0_q, c1_q);

   always_comb begin
      v1_d   = v1_q;
      c0_d   = c0_q;
      c1_d   = c1_q;
      slot_d = slot_q;
      last_d = last_q;
      if (!stall) begin
         v1_d = accept;
         if (accept) begin
            c0_d   = cls0;
            c1_d   = cls1;
            slot_d = in_slot;
            last_d = in_last;
         end
      end
   end

   // Handoff clears first so a same-edge write leaves only the new slot's bit set.
   always_comb begin
      out_valid_d = out_valid_q;
      mask_d      = mask_q;
      index_d     = index_q;
      if (fire) begin
         out_valid_d = 1'b0;
         mask_d      = '0;
      end
      if (wr) begin
         if (last_q) out_valid_d = 1'b1;
         for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (32'(slot_q) == k) begin
               index_d[LCDI_IDX_W*k +: LCDI_IDX_W] = idx;
               mask_d[k]                           = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         c0_q        <= '0;
         c1_q        <= '0;
         slot_q      <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         mask_q      <= '0;
         index_q     <= '0;
      end else begin
         v1_q        <= v1_d;
         c0_q        <= c0_d;
         c1_q        <= c1_d;
         slot_q      <= slot_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         mask_q      <= mask_d;
         index_q     <= index_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign slot_mask  = mask_q;
   assign index_flat = index_q;

endmodule

// File: tb/tb_lcdi_index_gen.sv
// Scoreboard bench for lcdi_index_gen: directed samples push expected bundles, a monitor pops them on handoff.
module tb_lcdi_index_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  data0 = '0, data1 = '0, data2 = '0;
   logic [2:0]  slot = '0;
   logic        last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [27:0] index_flat;
   logic [3:0]  slot_mask;

   logic        b_in_ready, b_out_valid;
   logic [41:0] b_index_flat;
   logic [5:0]  b_slot_mask;

   always #5 clk = ~clk;

   lcdi_index_gen #(.DATA_WIDTH(8), .NUM_SLOTS(4), .SLOT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data0_in   (data0),
      .data1_in   (data1),
      .data2_in   (data2),
      .in_slot    (slot),
      .in_last    (last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .index_flat (index_flat),
      .slot_mask  (slot_mask)
   );

   lcdi_index_gen #(.DATA_WIDTH(8), .NUM_SLOTS(6)) dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (b_in_ready),
      .data0_in   (data0),
      .data1_in   (data1),
      .data2_in   (data2),
      .in_slot    (slot),
      .in_last    (last),
      .out_valid  (b_out_valid),
      .out_ready  (out_ready),
      .index_flat (b_index_flat),
      .slot_mask  (b_slot_mask)
   );

   typedef struct {
      logic [3:0]  mask;
      logic [27:0] flat;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          ncmp = 0;
   int          nerr = 0;
   int          last_wait = 0;
   logic [6:0]  m_idx [4];
   logic [3:0]  m_mask = '0;
   logic [27:0] hold_flat;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [27:0] model_flat();
      return {m_idx[3], m_idx[2], m_idx[1], m_idx[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_idx[i] = '0;
      m_mask = '0;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [2:0] s, input logic l, input logic [6:0] e, input string nm);
      int w = 0;
      data0 = a; data1 = b; data2 = c; slot = s; last = l; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      last_wait = w;
      if (!in_ready) chk({nm, "_accept_timeout"}, {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (s < 3'd4) begin
         m_idx[s[1:0]] = e;
         m_mask[s[1:0]] = 1'b1;
      end
      if (l) begin
         q.push_back('{m_mask, model_flat(), nm});
         m_mask = '0;
      end
   endtask

   task automatic drain(input string nm);
      int w = 0;
      while (q.size() != 0 && w < 100) begin
         w++;
         @(negedge clk);
      end
      chk({nm, "_drain"}, 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_bundle", {63'd0, out_valid}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_mask"}, 64'(slot_mask), 64'(e.mask));
            chk({e.name, "_index"}, 64'(index_flat), 64'(e.flat));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mask", 64'(slot_mask), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_index", 64'(index_flat), 64'd0);

      // Class boundaries with data1=100, d1=0 (class 4 -> +36)
      send(8'd148, 8'd100, 8'd100, 3'd0, 1'b1, 7'd36, "cls_148");
      send(8'd147, 8'd100, 8'd100, 3'd0, 1'b1, 7'd37, "cls_147");
      send(8'd104, 8'd100, 8'd100, 3'd0, 1'b1, 7'd39, "cls_104");
      send(8'd103, 8'd100, 8'd100, 3'd0, 1'b1, 7'd40, "cls_103");
      send(8'd96,  8'd100, 8'd100, 3'd0, 1'b1, 7'd40, "cls_96");
      send(8'd95,  8'd100, 8'd100, 3'd0, 1'b1, 7'd41, "cls_95");
      send(8'd52,  8'd100, 8'd100, 3'd0, 1'b1, 7'd43, "cls_52");
      send(8'd51,  8'd100, 8'd100, 3'd0, 1'b1, 7'd44, "cls_51");
      drain("cls");

      send(8'd100, 8'd40, 8'd40, 3'd2, 1'b1, 7'd36, "single");
      chk("lat_edge1_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2_out_valid", 64'(out_valid), 64'd1);
      drain("single");

      send(8'd255, 8'd0,   8'd0,   3'd0, 1'b0, 7'd36, "b2b0");
      chk("b2b0_ready", 64'(last_wait), 64'd0);
      send(8'd0,   8'd255, 8'd255, 3'd1, 1'b0, 7'd44, "b2b1");
      chk("b2b1_ready", 64'(last_wait), 64'd0);
      send(8'd0,   8'd255, 8'd0,   3'd2, 1'b0, 7'd80, "b2b2");
      chk("b2b2_ready", 64'(last_wait), 64'd0);
      send(8'd40,  8'd40,  8'd100, 3'd3, 1'b1, 7'd4,  "b2b3");
      chk("b2b3_ready", 64'(last_wait), 64'd0);
      drain("b2b");

      // Backpressure: bundle A held while sample B waits in stage 1
      out_ready = 1'b0;
      send(8'd255, 8'd0, 8'd0, 3'd0, 1'b1, 7'd36, "bp_a");
      hold_flat = model_flat();
      send(8'd40, 8'd40, 8'd0, 3'd1, 1'b1, 7'd67, "bp_b");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_mask", 64'(slot_mask), 64'd1);
         chk("bp_index", 64'(index_flat), 64'(hold_flat));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain("bp");

      send(8'd100, 8'd40, 8'd40, 3'd1, 1'b0, 7'd36, "dup_a");
      send(8'd40,  8'd40, 8'd0,  3'd1, 1'b1, 7'd67, "dup_b");
      drain("dup");

      // Slot 5: dropped by the 4-slot instance, kept by the 6-slot one
      out_ready = 1'b0;
      send(8'd0, 8'd255, 8'd255, 3'd5, 1'b1, 7'd44, "oor5");
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      @(negedge clk);
      chk("oor5_out_valid", 64'(out_valid), 64'd1);
      chk("six_mask", 64'(b_slot_mask), 64'h20);
      chk("six_slot5", 64'(b_index_flat[41:35]), 64'd44);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain("oor");

      // Reset with a sample sitting in stage 1
      send(8'd100, 8'd40, 8'd40, 3'd3, 1'b1, 7'd36, "rst_mid");
      void'(q.pop_back());
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_mask", 64'(slot_mask), 64'd0);
      chk("midrst_index", 64'(index_flat), 64'd0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_no_bundle", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      send(8'd0, 8'd255, 8'd0, 3'd0, 1'b1, 7'd80, "post_rst");
      drain("post_rst");

      repeat (3) @(posedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/lcdi_index_gen.md
Name: lcdi_index_gen

Overview:
Parametrised, pipelined gradient-class index generator for the LCDI interpolation datapath.
- Per accepted sample: quantises two signed neighbour differences into 9 classes each and forms a 0..80 index.
- Stores each index into a slot selected by the sample, instead of a hard-wired state-to-register map.
- Emits the whole slot bundle with a valid/ready handshake when the group's last sample lands; stalls its input under output backpressure.

Parameters:
DATA_WIDTH, 8, unsigned pixel width.
NUM_SLOTS, 4, index slots per group (>=1).
SLOT_W, $clog2(NUM_SLOTS) (min 1), slot-id width.
T1, 4, inner threshold.
T2, 16, second threshold.
T3, 32, third threshold.
T4, 48, outer threshold; 0<T1<T2<T3<T4<2^DATA_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid&&in_ready
data0_in  in  DATA_WIDTH  left neighbour
data1_in  in  DATA_WIDTH  centre
data2_in  in  DATA_WIDTH  right neighbour
in_slot  in  SLOT_W  destination slot
in_last  in  1  last sample of group
out_valid  out  1  bundle valid
out_ready  in  1  consumer ready
index_flat  out  7*NUM_SLOTS  slot k at bits [7k+6:7k]
slot_mask  out  NUM_SLOTS  slots written in this group

Behaviour:
- Reset (rst_n low, asynchronous, active-low; clock clk): out_valid=0, slot_mask=0, index_flat=0, stage-1 valid=0. in_ready=1 after reset. Reset mid-group discards all in-flight data.
- Differences: d0=data0-data1 and d1=data2-data1, signed, DATA_WIDTH+1 bits; no overflow possible.
- Class c(d):
  - d>=T4 -> 0; T3<=d<T4 -> 1; T2<=d<T3 -> 2; T1<=d<T2 -> 3
  - -T1<=d<T1 -> 4
  - -T2<=d<-T1 -> 5; -T3<=d<-T2 -> 6; -T4<=d<-T3 -> 7; d<-T4 -> 8
- Index = c(d0) + 9*c(d1), 7 bits, range 0..80.
- stall = out_valid && !out_ready. in_ready = !stall (combinational).
- Stage 1 (edge after acceptance): register c0, c1, slot, last, v1=1. During stall, stage 1 holds its contents.
- Stage 2 (next edge, when v1 && !stall): compute index, write it into slot, set slot_mask[slot]. If last, set out_valid=1 at the same edge.
- Latency: accept at edge N -> index/out_valid visible after edge N+2. Throughput is 1 sample/clk without stall.
- Output handshake: bundle transfers when out_valid && out_ready. At that edge out_valid<=0 and slot_mask<=0. index_flat retains its old values; slot_mask defines validity.
- Simultaneous handoff and stage-2 write on the same edge: the write wins, so slot_mask = only the new slot's bit.
- Stage-2 write with last during an in-progress handoff: out_valid stays 1 with the new bundle.
- Duplicate slot within a group: later write overwrites; mask unchanged.
- in_slot >= NUM_SLOTS: index dropped, mask unchanged; in_last still honoured.
- Group of only out-of-range samples with last: out_valid=1 with slot_mask=0.
- While out_valid is held and stalled, index_flat and slot_mask are stable.

Decomposition:
- Shared package/define: LCDI_IDX_W=7, LCDI_NUM_CLASS=9, class constants CLS_POS_MAX=0 .. CLS_ZERO=4 .. CLS_NEG_MAX=8.
- One sub-module: lcdi_grad_classify. Parameters DATA_WIDTH, T1..T4; combinational signed diff in -> 4-bit class out. Instantiated twice in stage 0.

Test Plan:
- Class boundaries, one sample each, with data1=100 and data0 = 148/147/104/103/96/95/52/51: c0 = 0/1/3/4/4/5/7/8 respectively.
- Single sample, NUM_SLOTS=4: data0=100, data1=40, data2=40, slot 2, last -> after 2 edges out_valid=1, slot2=36, slot_mask=4'b0100.
- Extremes: (255,0,0) -> 36; (0,255,255) -> 44; (0,255,0) -> 80. Four back-to-back samples to slots 0..3, last on the 4th -> mask=4'b1111, in_ready stays 1 with out_ready=1.
- Backpressure: out_ready=0 after a bundle -> in_ready=0, bundle stable for 5 cycles, stage-1 sample held. Raise out_ready -> handoff; held sample lands with slot_mask = only its bit.
- Duplicate slot 1 (index 36, then 67 from (40,40,0)) -> slot1=67, mask bit1. Slot id 5 when NUM_SLOTS=6 is accepted; with NUM_SLOTS=4 and SLOT_W=3, id 5 is dropped.
- Assert rst_n low mid-group, with one sample in stage 1 -> out_valid=0, mask=0, no bundle after release.
